axi_arb_2m1s: RTL

- Two-master, one-slave arbiter for the team's simplified single-beat AXI (3-bit ID, 3-bit address, 8-bit data, 1-bit BRESP).
- Sits between two master ports and the slave side of axi_top.
- Read and write paths are arbitrated independently, each round-robin, with one outstanding transaction per path.
- Responses are routed back to the master that owns the current grant.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_arb_2m1s_rr_arb2.sv | 22 ++
 rtl/axi_arb_2m1s.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared widths and FSM encodings for the simplified single-beat AXI fabric.
// Imported by the arbiter and its helpers.
package axi_lite_pkg;

  localparam int AXI_ID_W   = 3;
  localparam int AXI_ADDR_W = 3;
  localparam int AXI_DATA_W = 8;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_t;

endpackage

// File: rtl/axi_arb_2m1s_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, on contention the
// master that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  // Grant selection from the request pair and the last-served pointer
  always_comb begin
    gnt_idx = 1'b0;
    gnt_vld = |req;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_arb_2m1s.sv
// Two-master / one-slave arbiter for the single-beat AXI fabric. Read and write
// paths each own a round-robin grant and allow one outstanding transaction.
module axi_arb_2m1s
  import axi_lite_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  // master side
  input  logic [2*ID_W-1:0]   master_ARID,
  input  logic [2*ADDR_W-1:0] master_ARADDR,
  input  logic [1:0]          master_ARVLD,
  output logic [1:0]          master_ARRDY,
  output logic [2*ID_W-1:0]   master_RID,
  output logic [2*DATA_W-1:0] master_RDATA,
  output logic [1:0]          master_RVLD,
  input  logic [1:0]          master_RRDY,
  input  logic [2*ID_W-1:0]   master_AWID,
  input  logic [2*ADDR_W-1:0] master_AWADDR,
  input  logic [1:0]          master_AWVLD,
  output logic [1:0]          master_AWRDY,
  input  logic [2*ID_W-1:0]   master_WID,
  input  logic [2*DATA_W-1:0] master_WDATA,
  input  logic [1:0]          master_WVLD,
  output logic [1:0]          master_WRDY,
  output logic [2*ID_W-1:0]   master_BID,
  output logic [1:0]          master_BRESP,
  output logic [1:0]          master_BVLD,
  input  logic [1:0]          master_BRDY,
  // slave side
  output logic [ID_W-1:0]     slave_ARID,
  output logic [ADDR_W-1:0]   slave_ARADDR,
  output logic                slave_ARVLD,
  input  logic                slave_ARRDY,
  input  logic [ID_W-1:0]     slave_RID,
  input  logic [DATA_W-1:0]   slave_RDATA,
  input  logic                slave_RVLD,
  output logic                slave_RRDY,
  output logic [ID_W-1:0]     slave_AWID,
  output logic [ADDR_W-1:0]   slave_AWADDR,
  output logic                slave_AWVLD,
  input  logic                slave_AWRDY,
  output logic [ID_W-1:0]     slave_WID,
  output logic [DATA_W-1:0]   slave_WDATA,
  output logic                slave_WVLD,
  input  logic                slave_WRDY,
  input  logic [ID_W-1:0]     slave_BID,
  input  logic                slave_BRESP,
  input  logic                slave_BVLD,
  output logic                slave_BRDY
);

  rd_state_t rd_state_r, rd_state_s;
  wr_state_t wr_state_r, wr_state_s;
  logic      rd_gnt_r, rd_last_r;
  logic      wr_gnt_r, wr_last_r;
  logic      rd_arb_idx_s, rd_arb_vld_s;
  logic      wr_arb_idx_s, wr_arb_vld_s;
  logic      ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  int        rd_sel_s, wr_sel_s;

  rr_arb2 u_rd_arb (
    .req     (master_ARVLD),
    .last    (rd_last_r),
    .gnt_idx (rd_arb_idx_s),
    .gnt_vld (rd_arb_vld_s)
  );

  rr_arb2 u_wr_arb (
    .req     (master_AWVLD),
    .last    (wr_last_r),
    .gnt_idx (wr_arb_idx_s),
    .gnt_vld (wr_arb_vld_s)
  );

  assign rd_sel_s = int'(rd_gnt_r);
  assign wr_sel_s = int'(wr_gnt_r);

  // Handshakes only count in the state that owns the channel
  assign ar_hs_s = (rd_state_r == RD_ADDR) && master_ARVLD[rd_gnt_r] && slave_ARRDY;
  assign r_hs_s  = (rd_state_r == RD_DATA) && slave_RVLD && master_RRDY[rd_gnt_r];
  assign aw_hs_s = (wr_state_r == WR_ADDR) && master_AWVLD[wr_gnt_r] && slave_AWRDY;
  assign w_hs_s  = (wr_state_r == WR_DATA) && master_WVLD[wr_gnt_r] && slave_WRDY;
  assign b_hs_s  = (wr_state_r == WR_RESP) && slave_BVLD && master_BRDY[wr_gnt_r];

  // Read path state, grant and last-served pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_r <= RD_IDLE;
      rd_gnt_r   <= 1'b0;
      rd_last_r  <= 1'b1;
    end else begin
      rd_state_r <= rd_state_s;
      if ((rd_state_r == RD_IDLE) && rd_arb_vld_s) begin
        rd_gnt_r <= rd_arb_idx_s;
      end
      if (r_hs_s) begin
        rd_last_r <= rd_gnt_r;
      end
    end
  end

  // Read path next state
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: if (rd_arb_vld_s) rd_state_s = RD_ADDR; else rd_state_s = RD_IDLE;
      RD_ADDR: if (ar_hs_s)      rd_state_s = RD_DATA; else rd_state_s = RD_ADDR;
      RD_DATA: if (r_hs_s)       rd_state_s = RD_IDLE; else rd_state_s = RD_DATA;
      default: rd_state_s = RD_IDLE;
    endcase
  end

  // Read path routing: only the granted master's lanes are ever non-zero
  always_comb begin
    master_ARRDY = '0;
    master_RID   = '0;
    master_RDATA = '0;
    master_RVLD  = '0;
    slave_ARID   = '0;
    slave_ARADDR = '0;
    slave_ARVLD  = 1'b0;
    slave_RRDY   = 1'b0;
    case (rd_state_r)
      RD_ADDR: begin
        slave_ARID             = master_ARID[ID_W*rd_sel_s +: ID_W];
        slave_ARADDR           = master_ARADDR[ADDR_W*rd_sel_s +: ADDR_W];
        slave_ARVLD            = master_ARVLD[rd_gnt_r];
        master_ARRDY[rd_gnt_r] = slave_ARRDY;
      end
      RD_DATA: begin
        master_RVLD[rd_gnt_r]                 = slave_RVLD;
        master_RID[ID_W*rd_sel_s +: ID_W]     = slave_RID;
        master_RDATA[DATA_W*rd_sel_s +: DATA_W] = slave_RDATA;
        slave_RRDY                            = master_RRDY[rd_gnt_r];
      end
      default: slave_RRDY = 1'b0;
    endcase
  end

  // Write path state, grant and last-served pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_r <= WR_IDLE;
      wr_gnt_r   <= 1'b0;
      wr_last_r  <= 1'b1;
    end else begin
      wr_state_r <= wr_state_s;
      if ((wr_state_r == WR_IDLE) && wr_arb_vld_s) begin
        wr_gnt_r <= wr_arb_idx_s;
      end
      if (b_hs_s) begin
        wr_last_r <= wr_gnt_r;
      end
    end
  end

  // Write path next state
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE: if (wr_arb_vld_s) wr_state_s = WR_ADDR; else wr_state_s = WR_IDLE;
      WR_ADDR: if (aw_hs_s)      wr_state_s = WR_DATA; else wr_state_s = WR_ADDR;
      WR_DATA: if (w_hs_s)       wr_state_s = WR_RESP; else wr_state_s = WR_DATA;
      WR_RESP: if (b_hs_s)       wr_state_s = WR_IDLE; else wr_state_s = WR_RESP;
      default: wr_state_s = WR_IDLE;
    endcase
  end

  // Write path routing; W is only forwarded once AW has been accepted
  always_comb begin
    master_AWRDY = '0;
    master_WRDY  = '0;
    master_BID   = '0;
    master_BRESP = '0;
    master_BVLD  = '0;
    slave_AWID   = '0;
    slave_AWADDR = '0;
    slave_AWVLD  = 1'b0;
    slave_WID    = '0;
    slave_WDATA  = '0;
    slave_WVLD   = 1'b0;
    slave_BRDY   = 1'b0;
    case (wr_state_r)
      WR_ADDR: begin
        slave_AWID             = master_AWID[ID_W*wr_sel_s +: ID_W];
        slave_AWADDR           = master_AWADDR[ADDR_W*wr_sel_s +: ADDR_W];
        slave_AWVLD            = master_AWVLD[wr_gnt_r];
        master_AWRDY[wr_gnt_r] = slave_AWRDY;
      end
      WR_DATA: begin
        slave_WID             = master_WID[ID_W*wr_sel_s +: ID_W];
        slave_WDATA           = master_WDATA[DATA_W*wr_sel_s +: DATA_W];
        slave_WVLD            = master_WVLD[wr_gnt_r];
        master_WRDY[wr_gnt_r] = slave_WRDY;
      end
      WR_RESP: begin
        master_BVLD[wr_gnt_r]             = slave_BVLD;
        master_BID[ID_W*wr_sel_s +: ID_W] = slave_BID;
        master_BRESP[wr_gnt_r]            = slave_BRESP;
        slave_BRDY                        = master_BRDY[wr_gnt_r];
      end
      default: slave_BRDY = 1'b0;
    endcase
  end

endmodule
